// File: rtl/keypad_scan_if.sv
// keypad_scan_if: bundle between the scan sequencer, the 1-of-16 decoder/matrix
// and the key consumer.
//   sel[3:0]      select code to the decoder
//   dec_en_n      decoder enable, active-low
//   sense_n       matrix return line, 0 = selected key pressed
//   key_code[3:0] accepted key
//   key_valid     accepted key available
//   key_ack       consumer takes key_code
// master = sequencer side, slave = decoder/matrix/consumer side.
interface keypad_scan_if;
  logic [3:0] sel;
  logic       dec_en_n;
  logic       sense_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;

  modport master (output sel, dec_en_n, key_code, key_valid,
                  input  sense_n, key_ack);
  modport slave  (input  sel, dec_en_n, key_code, key_valid,
                  output sense_n, key_ack);
endinterface

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: walks the decoder select through 16 key lines, samples the
// shared return line once per dwell, debounces a press, hands the key code to
// the consumer over valid/ack, then waits for a debounced release.
// Ports:
//   clk      system clock, rising edge
//   rst_n    synchronous active-low reset
//   scan_en  1 = scanning allowed
//   bus      keypad_scan_if.master (sel, dec_en_n, sense_n, key_code,
//            key_valid, key_ack)
module keypad_scan_ctrl #(
  parameter int DWELL    = 16,  // cycles per select position, 2..65535
  parameter int DEBOUNCE = 3    // identical samples to accept, 1..15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         scan_en,
  keypad_scan_if.master bus
);

  typedef enum logic [2:0] {IDLE, SCAN, CONFIRM, REPORT, RELEASE} state_t;

  state_t      state_q;
  logic [3:0]  sel_q;
  logic        dec_en_n_q;
  logic [3:0]  key_code_q;
  logic        key_valid_q;
  logic [15:0] cnt_q;
  logic [3:0]  deb_q;

  logic       sample;
  logic       deb_done;
  logic [3:0] deb_inc;

  // sense_n is evaluated only on the last cycle of each dwell
  assign sample   = (cnt_q == 16'(DWELL - 1));
  assign deb_inc  = deb_q + 4'd1;
  assign deb_done = (deb_inc == 4'(DEBOUNCE));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      dec_en_n_q  <= 1'b1;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      cnt_q       <= '0;
      deb_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          deb_q <= '0;
          if (scan_en) begin
            state_q    <= SCAN;
            sel_q      <= '0;
            dec_en_n_q <= 1'b0;
          end
        end

        SCAN: begin
          if (!scan_en) begin
            state_q    <= IDLE;
            dec_en_n_q <= 1'b1;
            cnt_q      <= '0;
            deb_q      <= '0;
          end else if (sample) begin
            cnt_q <= '0;
            if (sense_n_hi()) begin
              sel_q <= sel_q + 4'd1;
            end else if (DEBOUNCE == 1) begin
              state_q     <= REPORT;
              key_code_q  <= sel_q;
              key_valid_q <= 1'b1;
            end else begin
              state_q <= CONFIRM;
              deb_q   <= 4'd1;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        CONFIRM: begin
          if (!scan_en) begin
            // drop the half-confirmed candidate
            state_q    <= IDLE;
            dec_en_n_q <= 1'b1;
            cnt_q      <= '0;
            deb_q      <= '0;
          end else if (sample) begin
            cnt_q <= '0;
            if (!sense_n_hi()) begin
              if (deb_done) begin
                state_q     <= REPORT;
                key_code_q  <= sel_q;
                key_valid_q <= 1'b1;
                deb_q       <= '0;
              end else begin
                deb_q <= deb_inc;
              end
            end else begin
              // bounce: reject and move on past this line
              state_q <= SCAN;
              sel_q   <= sel_q + 4'd1;
              deb_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        REPORT: begin
          // scan_en and sense_n are ignored so an accepted key is never lost
          cnt_q <= '0;
          if (bus.key_ack && key_valid_q) begin
            key_valid_q <= 1'b0;
            state_q     <= RELEASE;
            deb_q       <= '0;
          end
        end

        RELEASE: begin
          if (sample) begin
            cnt_q <= '0;
            if (sense_n_hi()) begin
              if (deb_done) begin
                deb_q <= '0;
                if (scan_en) begin
                  state_q <= SCAN;
                  sel_q   <= key_code_q + 4'd1;
                end else begin
                  state_q    <= IDLE;
                  dec_en_n_q <= 1'b1;
                end
              end else begin
                deb_q <= deb_inc;
              end
            end else begin
              deb_q <= '0;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        default: begin
          state_q    <= IDLE;
          dec_en_n_q <= 1'b1;
          cnt_q      <= '0;
          deb_q      <= '0;
        end
      endcase
    end
  end

  function automatic logic sense_n_hi();
    return bus.sense_n;
  endfunction

  assign bus.sel       = sel_q;
  assign bus.dec_en_n  = dec_en_n_q;
  assign bus.key_code  = key_code_q;
  assign bus.key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl (DWELL=16, DEBOUNCE=3).
// A one-key matrix model pulls sense_n low while the chosen key is held and
// its line is the one the decoder drives.
module tb_keypad_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic scan_en;

  keypad_scan_if bus ();

  keypad_scan_ctrl #(.DWELL(16), .DEBOUNCE(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .scan_en (scan_en),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  int   key_k;
  logic key_down;

  assign bus.sense_n = ~(key_down && (int'(bus.sel) == key_k) && !bus.dec_en_n);

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic wait_sel(input int v, input int lim);
    int n = 0;
    while (int'(bus.sel) != v && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (n >= lim) chk("wait_sel_timeout", int'(bus.sel), v);
  endtask

  // Press key k as the scan arrives on it; lat = negedges from sel first
  // showing k until key_valid.
  task automatic press(input int k, output int lat, output int code);
    key_down = 1'b0;
    wait_sel((k + 15) % 16, 600);
    key_k    = k;
    key_down = 1'b1;
    wait_sel(k, 40);
    lat = 0;
    while (!bus.key_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    code = int'(bus.key_code);
  endtask

  // Ack for one cycle, then release; glitch re-presses across the third
  // release sample. rel = negedges from the ack edge until the line moves on.
  task automatic ack_release(input bit glitch, output int rel);
    bus.key_ack = 1'b1;
    @(negedge clk);
    bus.key_ack = 1'b0;
    chk("valid_after_ack", int'(bus.key_valid), 0);
    key_down = 1'b0;
    rel = 0;
    while (int'(bus.sel) == key_k && !bus.dec_en_n && rel < 200) begin
      @(negedge clk);
      rel++;
      if (glitch && rel == 40) key_down = 1'b1;
      if (glitch && rel == 50) key_down = 1'b0;
    end
  endtask

  typedef struct {
    int key;
    int ack_wait;
    bit glitch;
    int exp_code;
    int exp_lat;
    int exp_rel;
    int exp_sel;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int lat, code, rel, seen;

    vecs[0] = '{key: 9,  ack_wait: 40, glitch: 0, exp_code: 9,  exp_lat: 48, exp_rel: 48, exp_sel: 10};
    vecs[1] = '{key: 15, ack_wait: 3,  glitch: 0, exp_code: 15, exp_lat: 48, exp_rel: 48, exp_sel: 0};
    vecs[2] = '{key: 0,  ack_wait: 0,  glitch: 1, exp_code: 0,  exp_lat: 48, exp_rel: 96, exp_sel: 1};
    vecs[3] = '{key: 4,  ack_wait: 7,  glitch: 0, exp_code: 4,  exp_lat: 48, exp_rel: 48, exp_sel: 5};

    rst_n = 1'b0; scan_en = 1'b0; bus.key_ack = 1'b0; key_down = 1'b0; key_k = 0;
    repeat (3) @(negedge clk);
    chk("rst_sel", int'(bus.sel), 0);
    chk("rst_dec_en_n", int'(bus.dec_en_n), 1);
    chk("rst_valid", int'(bus.key_valid), 0);
    chk("rst_code", int'(bus.key_code), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_dec_en_n", int'(bus.dec_en_n), 1);

    // idle scan: sel steps every 16 cycles through a full wrap
    scan_en = 1'b1;
    @(negedge clk);
    seen = 0;
    for (int i = 0; i <= 16; i++) begin
      chk($sformatf("scan_sel_%0d", i), int'(bus.sel), i % 16);
      if (i < 16)
        for (int c = 0; c < 16; c++) begin
          if (bus.key_valid || bus.dec_en_n) seen++;
          @(negedge clk);
        end
    end
    chk("scan_no_valid_en_low", seen, 0);

    // table-driven press / ack / release
    foreach (vecs[v]) begin
      press(vecs[v].key, lat, code);
      chk($sformatf("v%0d_latency", v), lat, vecs[v].exp_lat);
      chk($sformatf("v%0d_code", v), code, vecs[v].exp_code);
      repeat (vecs[v].ack_wait) @(negedge clk);
      chk($sformatf("v%0d_valid_hold", v), int'(bus.key_valid), 1);
      chk($sformatf("v%0d_sel_hold", v), int'(bus.sel), vecs[v].key);
      ack_release(vecs[v].glitch, rel);
      chk($sformatf("v%0d_release", v), rel, vecs[v].exp_rel);
      chk($sformatf("v%0d_sel_after", v), int'(bus.sel), vecs[v].exp_sel);
    end

    // bounce on key 5: low, low, high -> rejected, sel moves to 6
    key_down = 1'b0;
    wait_sel(4, 600);
    key_k = 5; key_down = 1'b1;
    wait_sel(5, 40);
    seen = 0;
    for (int i = 1; i <= 48; i++) begin
      @(negedge clk);
      if (i == 40) key_down = 1'b0;
      if (bus.key_valid) seen++;
    end
    chk("bounce_sel", int'(bus.sel), 6);
    chk("bounce_no_valid", seen, 0);
    press(5, lat, code);
    chk("bounce_retry_lat", lat, 48);
    chk("bounce_retry_code", code, 5);
    ack_release(1'b0, rel);
    chk("bounce_retry_rel", rel, 48);

    // scan_en drop mid-CONFIRM
    key_down = 1'b0;
    wait_sel(1, 600);
    key_k = 2; key_down = 1'b1;
    wait_sel(2, 40);
    repeat (20) @(negedge clk);
    scan_en = 1'b0;
    @(negedge clk);
    chk("cfdrop_dec_en_n", int'(bus.dec_en_n), 1);
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus.key_valid) seen++;
    end
    chk("cfdrop_no_valid", seen, 0);
    chk("cfdrop_sel_hold", int'(bus.sel), 2);
    key_down = 1'b0; scan_en = 1'b1;
    @(negedge clk);
    chk("rescan_sel", int'(bus.sel), 0);
    chk("rescan_dec_en_n", int'(bus.dec_en_n), 0);

    // scan_en drop during REPORT: key kept, release ends in IDLE
    press(7, lat, code);
    chk("rpdrop_code", code, 7);
    scan_en = 1'b0;
    repeat (30) @(negedge clk);
    chk("rpdrop_valid", int'(bus.key_valid), 1);
    ack_release(1'b0, rel);
    chk("rpdrop_rel", rel, 48);
    chk("rpdrop_idle_dec", int'(bus.dec_en_n), 1);
    chk("rpdrop_idle_sel", int'(bus.sel), 7);

    // reset mid-CONFIRM
    scan_en = 1'b1;
    key_down = 1'b0;
    wait_sel(2, 600);
    key_k = 3; key_down = 1'b1;
    wait_sel(3, 40);
    repeat (20) @(negedge clk);
    rst_n = 1'b0; scan_en = 1'b0;
    @(negedge clk);
    chk("rst2_sel", int'(bus.sel), 0);
    chk("rst2_dec_en_n", int'(bus.dec_en_n), 1);
    chk("rst2_valid", int'(bus.key_valid), 0);
    chk("rst2_code", int'(bus.key_code), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst2_idle_dec", int'(bus.dec_en_n), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Scan sequencer that sits directly upstream of the team's 1-of-16 decoder.
- Drives the decoder's 4-bit select and active-low enable, so exactly one of 16 key lines is asserted at a time.
- Samples the common active-low return line from the key matrix, debounces the press, and hands the key code to the consumer over a valid/ack handshake.
- After the key is acknowledged, waits for a debounced release before resuming the scan.

Parameters:
DWELL, 16, clock cycles per select position; sense_n sampled on the last cycle of each dwell; legal range 2..65535.
DEBOUNCE, 3, consecutive identical samples (one per dwell) required to accept a press or a release; legal range 1..15.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  reset, synchronous, active-low.
scan_en  input  1  1 = scanning allowed.
sel  output  4  select code to the decoder's a[3:0].
dec_en_n  output  1  decoder enable, active-low (0 = one line driven).
sense_n  input  1  matrix return line; 0 = key on the currently selected line is pressed; synchronous to clk.
key_code  output  4  code of the accepted key; stable while key_valid=1.
key_valid  output  1  accepted key available.
key_ack  input  1  consumer accepts key_code.

Behaviour:
- Reset (rst_n=0 at a rising edge), from any state:
  - state=IDLE, sel=0, dec_en_n=1, key_code=0, key_valid=0.
  - dwell counter and debounce counter both 0.
- Dwell counter:
  - Runs 0..DWELL-1 in SCAN, CONFIRM and RELEASE; wraps to 0.
  - A "sample" is the edge at which count==DWELL-1; sense_n is evaluated at that edge.
  - Counter is reset to 0 on every state change and on every sel change.
- State behaviour and transitions:
  - IDLE: dec_en_n=1, sel holds. scan_en=1 -> SCAN with sel=0, dec_en_n=0.
  - SCAN: dec_en_n=0.
    - Sample with sense_n=1: sel <= sel+1 mod 16 (15 wraps to 0).
    - Sample with sense_n=0: if DEBOUNCE=1 -> REPORT; else -> CONFIRM with debounce count=1. sel holds in both cases.
  - CONFIRM: sel held.
    - Each low sample increments the count; when count reaches DEBOUNCE -> REPORT.
    - Any high sample -> SCAN with sel <= sel+1 (candidate rejected, count cleared).
  - REPORT:
    - On entry edge: key_code <= sel, key_valid <= 1.
    - sel held, dec_en_n=0, sense_n ignored.
    - key_ack=1 while key_valid=1 -> key_valid <= 0 at that edge, -> RELEASE.
    - key_ack while key_valid=0 is ignored in every state.
  - RELEASE: sel held.
    - Each high sample increments the count; each low sample clears it.
    - Count reaches DEBOUNCE -> SCAN with sel <= key_code+1, or -> IDLE with dec_en_n=1 if scan_en=0.
- scan_en deassertion:
  - In SCAN or CONFIRM: -> IDLE at the next edge; partial debounce is discarded.
  - In REPORT or RELEASE: no effect until release completes, so no accepted key is lost.
- Latency:
  - Key held on line k while SCAN dwells on k: key_valid rises DEBOUNCE*DWELL cycles after SCAN first dwells on k.
  - From IDLE with key 0 held: scan_en edge E0, key_valid=1 after edge E0+DEBOUNCE*DWELL.
- key_code changes only on entry to REPORT.
- A full scan with no keys takes 16*DWELL cycles, then repeats from sel=0.

Test Plan:
- Reset: drive rst_n=0 mid-CONFIRM -> next edge sel=0, dec_en_n=1, key_valid=0, state IDLE.
- Idle scan (DWELL=16, DEBOUNCE=3, sense_n=1 always, scan_en=1):
  - sel advances every 16 cycles 0,1,..,15,0.
  - dec_en_n=0 throughout.
  - key_valid never asserts.
- Press key 9 (sense_n=0 only when sel=9):
  - key_valid=1 exactly 48 cycles after sel first shows 9, with key_code=9.
  - Holding key_ack=0 keeps key_valid=1 and sel=9 indefinitely.
  - key_ack=1 for one cycle -> key_valid=0 next edge.
  - sense_n=1 for 3 dwells -> sel=10.
- Bounce: for key 5, samples low, low, high -> no key_valid; sel becomes 6; the next scan pass with a clean press reports 5.
- Wrap: press key 15, ack it, release -> sel returns to 0 after 3*16 cycles of high samples.
- scan_en drop:
  - During CONFIRM -> IDLE next edge, no report.
  - During REPORT -> key_valid stays 1 until ack; after release, IDLE with dec_en_n=1.
